// File: rtl/id_stage_pkg.sv
// Shared decode constants for the 16-bit pipeline: opcodes, ALU codes and special registers.
package id_stage_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  localparam logic [15:0] ZeroWord = 16'h0000;

  localparam logic [3:0] RegSp   = 4'd8;
  localparam logic [3:0] RegIh   = 4'd9;
  localparam logic [3:0] RegT    = 4'd10;
  localparam logic [3:0] RegNone = 4'd15;

  typedef enum logic [4:0] {
    OpcNop    = 5'b00001,
    OpcB      = 5'b00010,
    OpcBeqz   = 5'b00100,
    OpcBnez   = 5'b00101,
    OpcShift  = 5'b00110,
    OpcAddiu3 = 5'b01000,
    OpcAddiu  = 5'b01001,
    OpcMtsp   = 5'b01100,
    OpcLi     = 5'b01101,
    OpcLw     = 5'b10011,
    OpcRrr    = 5'b11100,
    OpcRr     = 5'b11101,
    OpcIh     = 5'b11110
  } opcode_e;

  typedef enum logic [2:0] {
    SelNop   = 3'd0,
    SelArith = 3'd1,
    SelLogic = 3'd2,
    SelShift = 3'd3,
    SelMove  = 3'd4,
    SelLoad  = 3'd5
  } alusel_e;

  typedef enum logic [2:0] {
    AluAdd  = 3'd0,
    AluSub  = 3'd1,
    AluAnd  = 3'd2,
    AluOr   = 3'd3,
    AluSll  = 3'd4,
    AluSra  = 3'd5,
    AluPass = 3'd6
  } aluop_e;

  typedef enum logic [2:0] {
    BrNone,
    BrAlways,
    BrEqz,
    BrNez,
    BrReg
  } br_kind_e;

endpackage

// File: rtl/id_fwd_mux.sv
// Per-port operand forwarding: EX result has priority over MEM, then the regfile.
module id_fwd_mux
  import id_stage_pkg::*;
(
  input  logic [3:0]  addr_i,
  input  logic [15:0] reg_data_i,
  input  logic        ex_we_i,
  input  logic [3:0]  ex_waddr_i,
  input  logic [15:0] ex_wdata_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_waddr_i,
  input  logic [15:0] mem_wdata_i,
  output logic [15:0] data_o
);

  always_comb begin
    data_o = reg_data_i;
    if (addr_i != RegNone) begin
      if (ex_we_i && (ex_waddr_i == addr_i)) begin
        data_o = ex_wdata_i;
      end else if (mem_we_i && (mem_waddr_i == addr_i)) begin
        data_o = mem_wdata_i;
      end
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: instruction decode, operand forwarding, branch resolution and
// load-use stall detection via a one-entry previous-LW tracker.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_i,
  input  logic [15:0] inst_i,
  input  logic [15:0] reg0_data_i,
  input  logic [15:0] reg1_data_i,
  input  logic        ex_we_i,
  input  logic [3:0]  ex_waddr_i,
  input  logic [15:0] ex_wdata_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_waddr_i,
  input  logic [15:0] mem_wdata_i,
  output logic [2:0]  alusel_o,
  output logic [2:0]  aluop_o,
  output logic [15:0] reg0_data_o,
  output logic [15:0] reg1_data_o,
  output logic        reg0_re_o,
  output logic        reg1_re_o,
  output logic [3:0]  reg0_addr_o,
  output logic [3:0]  reg1_addr_o,
  output logic        we_o,
  output logic [3:0]  waddr_o,
  output logic        stall_req,
  output logic        branch_flag_o,
  output logic [15:0] branch_addr_o
);

  logic        ld_v_q, ld_v_d;
  logic [3:0]  ld_a_q, ld_a_d;

  logic [2:0]  sel, op;
  logic        re0, re1, we, use_imm, is_lw;
  logic [3:0]  addr0, addr1, waddr;
  logic [15:0] imm, fwd0, fwd1, br_target;
  br_kind_e    br_kind;
  logic        br_taken;

  logic [3:0] rx, ry, rz;
  assign rx = {1'b0, inst_i[10:8]};
  assign ry = {1'b0, inst_i[7:5]};
  assign rz = {1'b0, inst_i[4:2]};

  always_comb begin
    sel     = SelNop;
    op      = AluAdd;
    re0     = 1'b0;
    re1     = 1'b0;
    addr0   = RegNone;
    addr1   = RegNone;
    we      = 1'b0;
    waddr   = 4'd0;
    imm     = ZeroWord;
    use_imm = 1'b0;
    is_lw   = 1'b0;
    br_kind = BrNone;
    unique case (inst_i[15:11])
      OpcAddiu: begin
        sel = SelArith; re0 = 1'b1; addr0 = rx; we = 1'b1; waddr = rx;
        imm = {{8{inst_i[7]}}, inst_i[7:0]}; use_imm = 1'b1;
      end
      OpcAddiu3: begin
        sel = SelArith; re0 = 1'b1; addr0 = rx; we = 1'b1; waddr = ry;
        imm = {{12{inst_i[3]}}, inst_i[3:0]}; use_imm = 1'b1;
      end
      OpcLi: begin
        sel = SelMove; op = AluPass; we = 1'b1; waddr = rx;
        imm = {8'd0, inst_i[7:0]}; use_imm = 1'b1;
      end
      OpcRrr: begin
        if (inst_i[1:0] == 2'b01 || inst_i[1:0] == 2'b11) begin
          sel = SelArith; op = inst_i[1] ? AluSub : AluAdd;
          re0 = 1'b1; addr0 = rx; re1 = 1'b1; addr1 = ry; we = 1'b1; waddr = rz;
        end
      end
      OpcRr: begin
        if (inst_i[4:0] == 5'b01100 || inst_i[4:0] == 5'b01101) begin
          sel = SelLogic; op = inst_i[0] ? AluOr : AluAnd;
          re0 = 1'b1; addr0 = rx; re1 = 1'b1; addr1 = ry; we = 1'b1; waddr = rx;
        end else if (inst_i[7:0] == 8'h00) begin
          re0 = 1'b1; addr0 = rx; br_kind = BrReg;
        end else if (inst_i[7:0] == 8'h40) begin
          sel = SelMove; op = AluPass; we = 1'b1; waddr = rx;
          imm = pc_i; use_imm = 1'b1;
        end
      end
      OpcShift: begin
        if (inst_i[1:0] == 2'b00 || inst_i[1:0] == 2'b11) begin
          sel = SelShift; op = inst_i[0] ? AluSra : AluSll;
          re0 = 1'b1; addr0 = ry; we = 1'b1; waddr = rx;
          // A zero shift-amount field encodes a shift by 8.
          imm = (inst_i[4:2] == 3'd0) ? 16'd8 : {13'd0, inst_i[4:2]};
          use_imm = 1'b1;
        end
      end
      OpcIh: begin
        if (inst_i[7:0] == 8'h00) begin
          sel = SelMove; op = AluPass; re1 = 1'b1; addr1 = RegIh; we = 1'b1; waddr = rx;
        end else if (inst_i[7:0] == 8'h01) begin
          sel = SelMove; op = AluPass; re1 = 1'b1; addr1 = rx; we = 1'b1; waddr = RegIh;
        end
      end
      OpcMtsp: begin
        if (inst_i[10:8] == 3'b100) begin
          sel = SelMove; op = AluPass; re1 = 1'b1; addr1 = ry; we = 1'b1; waddr = RegSp;
        end
      end
      OpcLw: begin
        sel = SelLoad; re0 = 1'b1; addr0 = rx; we = 1'b1; waddr = ry; is_lw = 1'b1;
        imm = {{11{inst_i[4]}}, inst_i[4:0]}; use_imm = 1'b1;
      end
      OpcB:    br_kind = BrAlways;
      OpcBeqz: begin re0 = 1'b1; addr0 = rx; br_kind = BrEqz; end
      OpcBnez: begin re0 = 1'b1; addr0 = rx; br_kind = BrNez; end
      default: ;
    endcase
  end

  id_fwd_mux u_fwd0 (
    .addr_i      (addr0),
    .reg_data_i  (reg0_data_i),
    .ex_we_i     (ex_we_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_wdata_i  (ex_wdata_i),
    .mem_we_i    (mem_we_i),
    .mem_waddr_i (mem_waddr_i),
    .mem_wdata_i (mem_wdata_i),
    .data_o      (fwd0)
  );

  id_fwd_mux u_fwd1 (
    .addr_i      (addr1),
    .reg_data_i  (reg1_data_i),
    .ex_we_i     (ex_we_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_wdata_i  (ex_wdata_i),
    .mem_we_i    (mem_we_i),
    .mem_waddr_i (mem_waddr_i),
    .mem_wdata_i (mem_wdata_i),
    .data_o      (fwd1)
  );

  always_comb begin
    br_taken  = 1'b0;
    br_target = ZeroWord;
    unique case (br_kind)
      BrAlways: begin br_taken = 1'b1; br_target = pc_i + {{5{inst_i[10]}}, inst_i[10:0]}; end
      BrEqz: begin br_taken = (fwd0 == ZeroWord); br_target = pc_i + {{8{inst_i[7]}}, inst_i[7:0]}; end
      BrNez: begin br_taken = (fwd0 != ZeroWord); br_target = pc_i + {{8{inst_i[7]}}, inst_i[7:0]}; end
      BrReg: begin br_taken = 1'b1; br_target = fwd0; end
      default: ;
    endcase
  end

  always_comb begin
    alusel_o      = 3'd0;
    aluop_o       = 3'd0;
    reg0_data_o   = ZeroWord;
    reg1_data_o   = ZeroWord;
    reg0_re_o     = 1'b0;
    reg1_re_o     = 1'b0;
    reg0_addr_o   = 4'd0;
    reg1_addr_o   = 4'd0;
    we_o          = 1'b0;
    waddr_o       = 4'd0;
    stall_req     = 1'b0;
    branch_flag_o = 1'b0;
    branch_addr_o = ZeroWord;
    if (rst != RstEnable) begin
      stall_req   = ld_v_q && ((re0 && addr0 == ld_a_q) || (re1 && addr1 == ld_a_q));
      reg0_re_o   = re0;
      reg1_re_o   = re1;
      reg0_addr_o = addr0;
      reg1_addr_o = addr1;
      reg0_data_o = re0 ? fwd0 : ZeroWord;
      reg1_data_o = use_imm ? imm : (re1 ? fwd1 : ZeroWord);
      waddr_o     = waddr;
      // Stalled instruction is issued as a bubble; it re-decodes next cycle.
      if (!stall_req) begin
        alusel_o      = sel;
        aluop_o       = op;
        we_o          = we;
        branch_flag_o = br_taken;
        branch_addr_o = br_taken ? br_target : ZeroWord;
      end
    end
  end

  assign ld_v_d = is_lw && !stall_req;
  assign ld_a_d = waddr_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_v_q <= 1'b0;
      ld_a_q <= 4'd0;
    end else begin
      ld_v_q <= ld_v_d;
      ld_a_q <= ld_a_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for the decode stage.
module tb_id_stage;

  logic        clk, rst;
  logic [15:0] pc_i, inst_i, reg0_data_i, reg1_data_i;
  logic        ex_we_i, mem_we_i;
  logic [3:0]  ex_waddr_i, mem_waddr_i;
  logic [15:0] ex_wdata_i, mem_wdata_i;
  logic [2:0]  alusel_o, aluop_o;
  logic [15:0] reg0_data_o, reg1_data_o;
  logic        reg0_re_o, reg1_re_o;
  logic [3:0]  reg0_addr_o, reg1_addr_o;
  logic        we_o;
  logic [3:0]  waddr_o;
  logic        stall_req, branch_flag_o;
  logic [15:0] branch_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .inst_i        (inst_i),
    .reg0_data_i   (reg0_data_i),
    .reg1_data_i   (reg1_data_i),
    .ex_we_i       (ex_we_i),
    .ex_waddr_i    (ex_waddr_i),
    .ex_wdata_i    (ex_wdata_i),
    .mem_we_i      (mem_we_i),
    .mem_waddr_i   (mem_waddr_i),
    .mem_wdata_i   (mem_wdata_i),
    .alusel_o      (alusel_o),
    .aluop_o       (aluop_o),
    .reg0_data_o   (reg0_data_o),
    .reg1_data_o   (reg1_data_o),
    .reg0_re_o     (reg0_re_o),
    .reg1_re_o     (reg1_re_o),
    .reg0_addr_o   (reg0_addr_o),
    .reg1_addr_o   (reg1_addr_o),
    .we_o          (we_o),
    .waddr_o       (waddr_o),
    .stall_req     (stall_req),
    .branch_flag_o (branch_flag_o),
    .branch_addr_o (branch_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Drive a new instruction just after a falling edge and let it settle.
  task automatic apply(input logic [15:0] inst);
    @(negedge clk);
    inst_i = inst;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pc_i = '0; inst_i = '0; reg0_data_i = '0; reg1_data_i = '0;
    ex_we_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
    mem_we_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0;
    #1;
    check_eq("rst_alusel", {13'd0, alusel_o}, 16'd0);
    check_eq("rst_we", {15'd0, we_o}, 16'd0);
    check_eq("rst_stall", {15'd0, stall_req}, 16'd0);
    check_eq("rst_addr0", {12'd0, reg0_addr_o}, 16'd0);
    check_eq("rst_addr1", {12'd0, reg1_addr_o}, 16'd0);
    check_eq("rst_br", {15'd0, branch_flag_o}, 16'd0);
    inst_i = 16'h4A0F; reg0_data_i = 16'h0001;
    #1;
    check_eq("rst_hold_data0", reg0_data_o, 16'h0000);
    check_eq("rst_hold_data1", reg1_data_o, 16'h0000);
    check_eq("rst_hold_re0", {15'd0, reg0_re_o}, 16'd0);

    @(negedge clk);
    rst = 1'b0;
    reg1_data_i = 16'hAAAA;

    // ADDIU R2,0x0F
    apply(16'h4A0F);
    check_eq("addiu_addr0", {12'd0, reg0_addr_o}, 16'd2);
    check_eq("addiu_re0", {15'd0, reg0_re_o}, 16'd1);
    check_eq("addiu_re1", {15'd0, reg1_re_o}, 16'd0);
    check_eq("addiu_addr1", {12'd0, reg1_addr_o}, 16'd15);
    check_eq("addiu_a", reg0_data_o, 16'h0001);
    check_eq("addiu_b", reg1_data_o, 16'h000F);
    check_eq("addiu_sel", {13'd0, alusel_o}, 16'd1);
    check_eq("addiu_op", {13'd0, aluop_o}, 16'd0);
    check_eq("addiu_we", {15'd0, we_o}, 16'd1);
    check_eq("addiu_waddr", {12'd0, waddr_o}, 16'd2);
    check_eq("addiu_br", {15'd0, branch_flag_o}, 16'd0);

    // EX beats MEM for the same register, then MEM alone.
    ex_we_i = 1'b1; ex_waddr_i = 4'd2; ex_wdata_i = 16'h1234;
    mem_we_i = 1'b1; mem_waddr_i = 4'd2; mem_wdata_i = 16'h5555;
    #1;
    check_eq("fwd_ex_wins", reg0_data_o, 16'h1234);
    ex_we_i = 1'b0;
    #1;
    check_eq("fwd_mem", reg0_data_o, 16'h5555);
    ex_waddr_i = 4'd3; ex_we_i = 1'b1;
    #1;
    check_eq("fwd_ex_other_reg", reg0_data_o, 16'h5555);
    ex_we_i = 1'b0; mem_we_i = 1'b0;

    // ADDIU3 R1,R2,-1
    apply(16'h414F);
    check_eq("addiu3_addr0", {12'd0, reg0_addr_o}, 16'd1);
    check_eq("addiu3_b", reg1_data_o, 16'hFFFF);
    check_eq("addiu3_waddr", {12'd0, waddr_o}, 16'd2);

    // LI R3,0x80 (zero-extended, no register read)
    apply(16'h6B80);
    check_eq("li_re0", {15'd0, reg0_re_o}, 16'd0);
    check_eq("li_a", reg0_data_o, 16'h0000);
    check_eq("li_b", reg1_data_o, 16'h0080);
    check_eq("li_sel", {13'd0, alusel_o}, 16'd4);
    check_eq("li_op", {13'd0, aluop_o}, 16'd6);
    check_eq("li_waddr", {12'd0, waddr_o}, 16'd3);

    // SUBU R3,R1,R4
    reg0_data_i = 16'h0007; reg1_data_i = 16'h0003;
    apply(16'hE333);
    check_eq("subu_op", {13'd0, aluop_o}, 16'd1);
    check_eq("subu_addr1", {12'd0, reg1_addr_o}, 16'd1);
    check_eq("subu_b", reg1_data_o, 16'h0003);
    check_eq("subu_waddr", {12'd0, waddr_o}, 16'd4);

    // SLL R1,R2,0 -> shift by 8
    apply(16'h3140);
    check_eq("sll_addr0", {12'd0, reg0_addr_o}, 16'd2);
    check_eq("sll_b", reg1_data_o, 16'h0008);
    check_eq("sll_sel", {13'd0, alusel_o}, 16'd3);
    check_eq("sll_op", {13'd0, aluop_o}, 16'd4);
    check_eq("sll_waddr", {12'd0, waddr_o}, 16'd1);

    // MFPC R2
    pc_i = 16'h0010;
    apply(16'hEA40);
    check_eq("mfpc_b", reg1_data_o, 16'h0010);
    check_eq("mfpc_waddr", {12'd0, waddr_o}, 16'd2);

    // LW R1,R3,0 then ADDU R3,R1,R4: load-use stall for one cycle
    apply(16'h9960);
    check_eq("lw_sel", {13'd0, alusel_o}, 16'd5);
    check_eq("lw_waddr", {12'd0, waddr_o}, 16'd3);
    check_eq("lw_nostall", {15'd0, stall_req}, 16'd0);
    apply(16'hE331);
    check_eq("lu_stall", {15'd0, stall_req}, 16'd1);
    check_eq("lu_bubble_we", {15'd0, we_o}, 16'd0);
    check_eq("lu_bubble_sel", {13'd0, alusel_o}, 16'd0);
    @(negedge clk); #1;
    check_eq("lu_release", {15'd0, stall_req}, 16'd0);
    check_eq("lu_release_we", {15'd0, we_o}, 16'd1);
    check_eq("lu_release_waddr", {12'd0, waddr_o}, 16'd4);
    check_eq("lu_release_sel", {13'd0, alusel_o}, 16'd1);

    // BEQZ R0,-2 at pc_i 0x0010
    reg0_data_i = 16'h0000;
    apply(16'h20FE);
    check_eq("beqz_taken", {15'd0, branch_flag_o}, 16'd1);
    check_eq("beqz_addr", branch_addr_o, 16'h000E);
    reg0_data_i = 16'h0005;
    #1;
    check_eq("beqz_not_taken", {15'd0, branch_flag_o}, 16'd0);
    check_eq("beqz_nt_addr", branch_addr_o, 16'h0000);

    // B -1
    apply(16'h17FF);
    check_eq("b_flag", {15'd0, branch_flag_o}, 16'd1);
    check_eq("b_addr", branch_addr_o, 16'h000F);

    // JR R5
    reg0_data_i = 16'h0200;
    apply(16'hED00);
    check_eq("jr_addr0", {12'd0, reg0_addr_o}, 16'd5);
    check_eq("jr_flag", {15'd0, branch_flag_o}, 16'd1);
    check_eq("jr_addr", branch_addr_o, 16'h0200);
    check_eq("jr_we", {15'd0, we_o}, 16'd0);

    // Illegal encoding decodes as NOP
    apply(16'hFFFF);
    check_eq("ill_sel", {13'd0, alusel_o}, 16'd0);
    check_eq("ill_op", {13'd0, aluop_o}, 16'd0);
    check_eq("ill_we", {15'd0, we_o}, 16'd0);
    check_eq("ill_re", {14'd0, reg0_re_o, reg1_re_o}, 16'd0);
    check_eq("ill_data", reg0_data_o | reg1_data_o, 16'h0000);
    check_eq("ill_br", {15'd0, branch_flag_o}, 16'd0);

    // Reset clears a pending load tracker
    apply(16'h9960);
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    inst_i = 16'hE331;
    #1;
    check_eq("rst_clears_tracker", {15'd0, stall_req}, 16'd0);
    check_eq("rst_clears_we", {15'd0, we_o}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
